// File: rtl/register_file_mp.sv
// Multi-read-port register file with byte-enabled writes, write-first bypass on every read
// port, and a hardware clear sweep that runs after reset and on request.
module register_file_mp #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 5,
  parameter  int REG_COUNT  = 32,
  parameter  int NUM_RD     = 2,
  parameter  bit ZERO_REG   = 1'b1,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_req,
  output logic                         ready,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [BE_WIDTH-1:0]          wr_be,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_ack,
  output logic                         wr_err,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data
);

  localparam int                    CLR_W     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [CLR_W-1:0]      LAST_IDX  = CLR_W'(REG_COUNT - 1);
  localparam logic [ADDR_WIDTH:0]   REG_LIMIT = (ADDR_WIDTH + 1)'(REG_COUNT);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CLR_W-1:0]       clr_idx;
  logic [CLR_W-1:0]       clr_idx_next;
  logic [ADDR_WIDTH-1:0]  clr_addr;

  logic [DATA_WIDTH-1:0]  regs [REG_COUNT];

  logic                   wr_accept;
  logic                   wr_in_range;
  logic                   wr_commit;
  logic [DATA_WIDTH-1:0]  wr_old;
  logic [DATA_WIDTH-1:0]  wr_merged;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_next;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < REG_LIMIT);
  endfunction

  function automatic logic addr_is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 1'b0) && (a == '0);
  endfunction

  // A clear request outranks a same-cycle write, so the write is neither acked nor flagged.
  assign wr_accept   = (state == ST_READY) && wr_en && !clr_req;
  assign wr_in_range = addr_in_range(wr_addr);
  assign wr_commit   = wr_accept && wr_in_range && !addr_is_zero_reg(wr_addr);
  assign clr_addr    = ADDR_WIDTH'(clr_idx);
  assign ready       = (state == ST_READY);

  always_comb begin
    wr_old = '0;
    if (wr_in_range) begin
      wr_old = regs[wr_addr];
    end
    wr_merged = wr_old;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (wr_be[i]) begin
        wr_merged[i*8 +: 8] = wr_data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      ST_INIT: begin
        if (clr_idx == LAST_IDX) begin
          state_next   = ST_READY;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx + CLR_W'(1);
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_next   = ST_INIT;
          clr_idx_next = '0;
        end
      end
      default: begin
        state_next   = ST_INIT;
        clr_idx_next = '0;
      end
    endcase
  end

  // Storage has no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      regs[clr_addr] <= '0;
    end else if (wr_commit) begin
      regs[wr_addr] <= wr_merged;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    a       = '0;
    rd_next = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      if ((state == ST_READY) && addr_in_range(a) && !addr_is_zero_reg(a)) begin
        if (wr_commit && (wr_addr == a)) begin
          rd_next[p*DATA_WIDTH +: DATA_WIDTH] = wr_merged;
        end else begin
          rd_next[p*DATA_WIDTH +: DATA_WIDTH] = regs[a];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_idx <= '0;
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
      rd_data <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
      wr_ack  <= wr_accept && wr_in_range;
      wr_err  <= wr_accept && !wr_in_range;
      rd_data <= rd_next;
    end
  end

endmodule
